// File: rtl/decode_stage.sv
// decode_stage: instruction decode with 8x16 write-through register file and load-use stall FSM
module decode_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instruction,
  input  logic [15:0] immediate,
  input  logic        wbRegWrite,
  input  logic [3:0]  wbAddress,
  input  logic [15:0] wbData,
  input  logic        exMemRead,
  input  logic [3:0]  exDestAddress,
  output logic        RegWrite,
  output logic        MemOrReg,
  output logic        MemWrite,
  output logic        MemRead,
  output logic        SPOrALUres,
  output logic        immOrReg,
  output logic        updateStatus,
  output logic [1:0]  SPOpeartion,
  output logic [1:0]  carryFlag,
  output logic [3:0]  AlUControl,
  output logic [3:0]  regDestAddress,
  output logic [3:0]  regSrcAddress,
  output logic [15:0] RegDest,
  output logic [15:0] RegSrc,
  output logic [15:0] oImm,
  output logic        stall
);
  typedef enum logic {IDLE, STALL} state_t;
  state_t state_q, state_d;
  logic [15:0] regs_q [8];
  logic [4:0] op;
  logic [2:0] rdst, rsrc;
  logic [14:0] ctrl;
  logic use_dst, use_src, hazard, wb_on, unused_bits;
  assign op = instruction[15:11];
  assign rdst = instruction[10:8];
  assign rsrc = instruction[7:5];
  assign unused_bits = ^{instruction[4:0], wbAddress[3], exDestAddress[3]};
  // ctrl = {RegWrite, MemOrReg, MemWrite, MemRead, SPOrALUres, immOrReg, updateStatus, SPOp, carry, alu}
  always_comb begin
    ctrl = '0;
    use_dst = 1'b0;
    use_src = 1'b0;
    case (op)
      5'd1:  ctrl = {7'b0000000, 2'b00, 2'b01, 4'd0};
      5'd2:  ctrl = {7'b0000000, 2'b00, 2'b10, 4'd0};
      5'd3:  {ctrl, use_dst} = {7'b1000001, 4'b0, 4'd1, 1'b1};
      5'd4:  {ctrl, use_dst} = {7'b1000001, 4'b0, 4'd2, 1'b1};
      5'd5:  {ctrl, use_dst} = {7'b1000001, 4'b0, 4'd3, 1'b1};
      5'd8:  {ctrl, use_src} = {7'b1000000, 4'b0, 4'd4, 1'b1};
      5'd9:  {ctrl, use_dst, use_src} = {7'b1000001, 4'b0, 4'd5, 2'b11};
      5'd10: {ctrl, use_dst, use_src} = {7'b1000001, 4'b0, 4'd6, 2'b11};
      5'd11: {ctrl, use_dst, use_src} = {7'b1000001, 4'b0, 4'd7, 2'b11};
      5'd12: {ctrl, use_dst, use_src} = {7'b1000001, 4'b0, 4'd8, 2'b11};
      5'd13: {ctrl, use_dst} = {7'b1000011, 4'b0, 4'd9, 1'b1};
      5'd14: {ctrl, use_dst} = {7'b1000011, 4'b0, 4'd10, 1'b1};
      5'd16: {ctrl, use_dst} = {7'b0010100, 2'b01, 2'b00, 4'd0, 1'b1};
      5'd17: ctrl = {7'b1101100, 2'b10, 2'b00, 4'd0};
      5'd18: ctrl = {7'b1000010, 4'b0, 4'd11};
      5'd19: {ctrl, use_src} = {7'b1101010, 4'b0, 4'd5, 1'b1};
      5'd20: {ctrl, use_dst, use_src} = {7'b0010010, 4'b0, 4'd5, 2'b11};
      default: ;
    endcase
  end
  assign hazard = exMemRead & ((use_dst & (exDestAddress[2:0] == rdst)) |
                               (use_src & (exDestAddress[2:0] == rsrc)));
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb state_d = (state_q == IDLE && hazard) ? STALL : IDLE;
  always_comb stall = ~reset & (state_q == IDLE) & hazard;
  assign {RegWrite, MemOrReg, MemWrite, MemRead, SPOrALUres, immOrReg, updateStatus,
          SPOpeartion, carryFlag, AlUControl} = (reset | stall) ? '0 : ctrl;
  always_ff @(posedge clk) begin
    if (reset) regs_q <= '{default: '0};
    else if (wbRegWrite) regs_q[wbAddress[2:0]] <= wbData;
  end
  // write-through: a same-cycle write is visible to the read ports
  assign wb_on = wbRegWrite & ~reset;
  assign RegDest = (wb_on && wbAddress[2:0] == rdst) ? wbData : regs_q[rdst];
  assign RegSrc = (wb_on && wbAddress[2:0] == rsrc) ? wbData : regs_q[rsrc];
  assign regDestAddress = {1'b0, rdst};
  assign regSrcAddress = {1'b0, rsrc};
  assign oImm = immediate;
endmodule
